// File: rtl/arf124b256e1r1w0cbbehcaa4acw_wr_sched_pkg.sv
// Shared types and defaults for the 124b x 256 1R1W array write-port scheduler.
package arf124b256e1r1w0cbbehcaa4acw_wr_sched_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 124;
    localparam int MAX_NUM_REQ = 8;
    localparam int RR_IDX_W    = $clog2(MAX_NUM_REQ);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BLOCK = 2'd2
    } state_t;

    typedef logic [RR_IDX_W-1:0] rr_idx_t;

    // Next round-robin position after idx, wrapping at n requesters.
    function automatic rr_idx_t rr_next(input rr_idx_t idx, input int n);
        return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/arf124b256e1r1w0cbbehcaa4acw_wr_sched_if.sv
// Write-request bus between the requesting pipeline stages and the scheduler.
interface arf124b256e1r1w0cbbehcaa4acw_wr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 124
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/arf124b256e1r1w0cbbehcaa4acw_rr_arb.sv
// Round-robin arbiter: first valid requester at or after the pointer wins.
module arf124b256e1r1w0cbbehcaa4acw_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int c;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        c       = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(i_ptr) + k;
            if (c >= N) c = c - N;
            if (!o_any && i_valid[c]) begin
                o_any      = 1'b1;
                o_grant[c] = 1'b1;
                o_idx      = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/arf124b256e1r1w0cbbehcaa4acw_wr_sched.sv
// Write-port scheduler: post-reset zero-fill sweep, round-robin write grant,
// one-cycle write stage driving the array and its clock gate, read bypass.
module arf124b256e1r1w0cbbehcaa4acw_wr_sched
    import arf124b256e1r1w0cbbehcaa4acw_wr_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INIT_EN = 1,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    arf124b256e1r1w0cbbehcaa4acw_wr_sched_if.slave req,
    input  logic              i_cfg_wr_block,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_arr_wen,
    output logic [ADDR_W-1:0] o_arr_waddr,
    output logic [DATA_W-1:0] o_arr_wdata,
    output logic              o_arr_wclk_en,
    output logic              o_rd_byp_hit,
    output logic [DATA_W-1:0] o_rd_byp_data,
    output logic [IDX_W-1:0]  o_grant_id,
    output logic              o_init_done,
    output logic              o_idle
);

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    rr_idx_t           r_ptr;
    rr_idx_t           r_grant_id;
    logic              r_wen;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_init_done;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    logic               w_run;
    logic               w_xfer;

    arf124b256e1r1w0cbbehcaa4acw_rr_arb #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_valid (req.req_valid),
        .i_ptr   (IDX_W'(r_ptr)),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_run         = (r_state == ST_RUN);
    assign w_xfer        = w_run & w_any;
    assign req.req_ready = w_run ? w_grant : '0;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT:  if (r_cnt == ADDR_W'(DEPTH - 1)) w_state_next = ST_RUN;
            ST_RUN:   if (i_cfg_wr_block)              w_state_next = ST_BLOCK;
            ST_BLOCK: if (!i_cfg_wr_block)             w_state_next = ST_RUN;
            default:                                   w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wen       <= (r_state == ST_INIT) | w_xfer;
            // Flag rises once the FSM has left INIT, i.e. after the last sweep write is issued.
            r_init_done <= r_init_done | (r_state != ST_INIT);
            if (r_state == ST_INIT) begin
                r_waddr <= r_cnt;
                r_wdata <= '0;
                r_cnt   <= (r_cnt == ADDR_W'(DEPTH - 1)) ? '0 : r_cnt + 1'b1;
            end else if (w_xfer) begin
                r_waddr    <= req.req_addr[w_idx*ADDR_W +: ADDR_W];
                r_wdata    <= req.req_data[w_idx*DATA_W +: DATA_W];
                r_grant_id <= rr_idx_t'(w_idx);
                r_ptr      <= rr_next(rr_idx_t'(w_idx), NUM_REQ);
            end
        end
    end

    assign o_arr_wen     = r_wen;
    assign o_arr_waddr   = r_waddr;
    assign o_arr_wdata   = r_wdata;
    assign o_arr_wclk_en = r_wen;
    assign o_rd_byp_hit  = i_rd_en & r_wen & (i_rd_addr == r_waddr);
    assign o_rd_byp_data = o_rd_byp_hit ? r_wdata : '0;
    assign o_grant_id    = IDX_W'(r_grant_id);
    assign o_init_done   = r_init_done;
    assign o_idle        = ~r_wen & ~|req.req_valid & (r_state != ST_INIT);

endmodule

// File: tb/tb_arf124b256e1r1w0cbbehcaa4acw_wr_sched.sv
// Directed self-checking bench for the array write-port scheduler.
module tb_arf124b256e1r1w0cbbehcaa4acw_wr_sched;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 124;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_wr_block = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          arr_wen, arr_wclk_en, rd_byp_hit, init_done, idle;
    logic [AW-1:0] arr_waddr;
    logic [DW-1:0] arr_wdata, rd_byp_data;
    logic [1:0]    grant_id;

    int checks = 0;
    int errors = 0;

    arf124b256e1r1w0cbbehcaa4acw_wr_sched_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    arf124b256e1r1w0cbbehcaa4acw_wr_sched #(
        .NUM_REQ(NR), .DATA_W(DW), .DEPTH(256), .ADDR_W(AW), .INIT_EN(1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (bus),
        .i_cfg_wr_block (cfg_wr_block),
        .i_rd_en        (rd_en),
        .i_rd_addr      (rd_addr),
        .o_arr_wen      (arr_wen),
        .o_arr_waddr    (arr_waddr),
        .o_arr_wdata    (arr_wdata),
        .o_arr_wclk_en  (arr_wclk_en),
        .o_rd_byp_hit   (rd_byp_hit),
        .o_rd_byp_data  (rd_byp_data),
        .o_grant_id     (grant_id),
        .o_init_done    (init_done),
        .o_idle         (idle)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        logic [30:0] w;
        w = 31'h1234_5670 + 31'(i);
        return {w, w, w, w};
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        checks++;
        if ({arr_wen, arr_wclk_en, rd_byp_hit, init_done, idle} !== 5'b0 || arr_waddr !== '0 ||
            arr_wdata !== '0 || grant_id !== 2'd0 || bus.req_ready !== 4'b0) begin
            errors++;
            $display("FAIL %s: wen=%b clk_en=%b hit=%b done=%b idle=%b waddr=%h gid=%0d ready=%b, all required 0",
                     tag, arr_wen, arr_wclk_en, rd_byp_hit, init_done, idle, arr_waddr, grant_id, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        rd_en = 1'b1;
        rd_addr = 8'h00;
        #1;
        chk_zero_outputs("reset_outputs");
        rd_en = 1'b0;
    endtask

    task automatic test_sweep();
        int bad;
        bad = 0;
        bus.req_valid = 4'hF;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (i == 5) begin rd_en = 1'b1; rd_addr = 8'd5; #1; end
            checks++;
            if (arr_wen !== 1'b1 || arr_wclk_en !== 1'b1 || arr_waddr !== AW'(i) || arr_wdata !== '0 ||
                init_done !== 1'b0 || (i < 255 && bus.req_ready !== 4'b0)) begin
                errors++; bad++;
                if (bad < 4)
                    $display("FAIL sweep[%0d]: wen=%b clk_en=%b waddr=%0d done=%b ready=%b, required 1 1 %0d 0 0000",
                             i, arr_wen, arr_wclk_en, arr_waddr, init_done, bus.req_ready, i);
            end
            if (i == 5) begin
                checks++;
                if (rd_byp_hit !== 1'b1 || rd_byp_data !== '0) begin
                    errors++;
                    $display("FAIL sweep_bypass: hit=%b data=%h, required 1 0", rd_byp_hit, rd_byp_data);
                end
                rd_en = 1'b0;
            end
        end
        bus.req_valid = 4'h0;
        step();
        checks++;
        if (init_done !== 1'b1 || arr_wen !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL sweep_done: done=%b wen=%b idle=%b, required 1 0 1", init_done, arr_wen, idle);
        end
        $display("sweep: 256 zero writes issued, init_done=%b", init_done);
    endtask

    task automatic test_single();
        set_req(2, 8'h5A, {DW{1'b1}});
        bus.req_valid = 4'b0100;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b required 0100", bus.req_ready);
        end
        step();
        bus.req_valid = 4'b0000;
        checks++;
        if (arr_wen !== 1'b1 || arr_waddr !== 8'h5A || arr_wdata !== {DW{1'b1}} || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL single_write: wen=%b waddr=%h gid=%0d, required 1 5a 2", arr_wen, arr_waddr, grant_id);
        end
        $display("single: req 2 -> waddr=%h gid=%0d", arr_waddr, grant_id);
    endtask

    task automatic test_round_robin();
        int exp;
        exp = 3;
        for (int i = 0; i < NR; i++) set_req(i, AW'(8'h20 + i), pat(i));
        bus.req_valid = 4'hF;
        for (int n = 0; n < 8; n++) begin
            #1;
            checks++;
            if (bus.req_ready !== 4'(1 << exp)) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b required %b", n, bus.req_ready, 4'(1 << exp));
            end
            step();
            checks++;
            if (arr_wen !== 1'b1 || arr_waddr !== AW'(8'h20 + exp) || arr_wdata !== pat(exp) || grant_id !== 2'(exp)) begin
                errors++;
                $display("FAIL rr_write[%0d]: wen=%b waddr=%h gid=%0d, required 1 %h %0d",
                         n, arr_wen, arr_waddr, grant_id, 8'h20 + exp, exp);
            end
            $display("rr: grant %0d waddr=%h", grant_id, arr_waddr);
            exp = (exp + 1) % NR;
        end
        bus.req_valid = 4'h0;
        step();
        checks++;
        if (arr_wen !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL rr_drain: wen=%b idle=%b, required 0 1", arr_wen, idle);
        end
    endtask

    task automatic test_block();
        // Pointer is 3 here, so with reqs 0,1 valid the search lands on 0.
        bus.req_valid = 4'b0011;
        cfg_wr_block = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL block_same_cycle_ready: got %b required 0001", bus.req_ready);
        end
        step();
        checks++;
        if (arr_wen !== 1'b1 || arr_waddr !== 8'h20 || bus.req_ready !== 4'b0 || idle !== 1'b0) begin
            errors++;
            $display("FAIL block_inflight: wen=%b waddr=%h ready=%b idle=%b, required 1 20 0000 0",
                     arr_wen, arr_waddr, bus.req_ready, idle);
        end
        step();
        checks++;
        if (arr_wen !== 1'b0 || bus.req_ready !== 4'b0 || idle !== 1'b0) begin
            errors++;
            $display("FAIL block_hold: wen=%b ready=%b idle=%b, required 0 0000 0", arr_wen, bus.req_ready, idle);
        end
        cfg_wr_block = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0) begin
            errors++;
            $display("FAIL block_release_same_cycle: ready=%b required 0000", bus.req_ready);
        end
        step();
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL block_resume_ready: got %b required 0010", bus.req_ready);
        end
        step();
        checks++;
        if (arr_wen !== 1'b1 || arr_waddr !== 8'h21 || grant_id !== 2'd1 || bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL block_resume_write: wen=%b waddr=%h gid=%0d ready=%b, required 1 21 1 0001",
                     arr_wen, arr_waddr, grant_id, bus.req_ready);
        end
        $display("block: resumed with grant %0d waddr=%h", grant_id, arr_waddr);
        bus.req_valid = 4'b0000;
        step();
    endtask

    task automatic test_bypass();
        set_req(0, 8'h10, DW'(12'hABC));
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = 4'b0000;
        rd_en = 1'b1;
        rd_addr = 8'h10;
        #1;
        checks++;
        if (rd_byp_hit !== 1'b1 || rd_byp_data !== DW'(12'hABC)) begin
            errors++;
            $display("FAIL bypass_hit: hit=%b data=%h, required 1 abc", rd_byp_hit, rd_byp_data);
        end
        rd_addr = 8'h11;
        #1;
        checks++;
        if (rd_byp_hit !== 1'b0 || rd_byp_data !== '0) begin
            errors++;
            $display("FAIL bypass_miss: hit=%b data=%h, required 0 0", rd_byp_hit, rd_byp_data);
        end
        rd_addr = 8'h10;
        step();
        checks++;
        if (rd_byp_hit !== 1'b0) begin
            errors++;
            $display("FAIL bypass_no_write: hit=%b required 0", rd_byp_hit);
        end
        $display("bypass: write 0x10 forwarded, 0x11 not forwarded");
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int k = 0; k <= 100; k++) step();
        checks++;
        if (arr_wen !== 1'b1 || arr_waddr !== 8'd100) begin
            errors++;
            $display("FAIL mid_sweep_pos: wen=%b waddr=%0d, required 1 100", arr_wen, arr_waddr);
        end
        rst = 1'b1;
        #1;
        chk_zero_outputs("mid_sweep_reset");
        step();
        chk_zero_outputs("mid_sweep_reset_held");
        rst = 1'b0;
        step();
        checks++;
        if (arr_wen !== 1'b1 || arr_waddr !== 8'd0 || arr_wdata !== '0) begin
            errors++;
            $display("FAIL sweep_restart0: wen=%b waddr=%0d, required 1 0", arr_wen, arr_waddr);
        end
        step();
        checks++;
        if (arr_wen !== 1'b1 || arr_waddr !== 8'd1) begin
            errors++;
            $display("FAIL sweep_restart1: wen=%b waddr=%0d, required 1 1", arr_wen, arr_waddr);
        end
        $display("reset mid-sweep: restarted at waddr=%0d", arr_waddr);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_sweep();
        test_single();
        test_round_robin();
        test_block();
        test_bypass();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arf124b256e1r1w0cbbehcaa4acw_wr_sched.md
Name: arf124b256e1r1w0cbbehcaa4acw_wr_sched

Overview:
Write-port scheduler for the 124b x 256-entry 1R1W array. Round-robin arbitration of NUM_REQ write requesters onto the single write port, with a post-reset zero-fill sweep of all entries. Drives the write-clock-gate enable and forwards same-cycle write data to the read port on an address collision. Sits between the requesting pipeline stages and the array plus its clock-gate cell.

Parameters:
NUM_REQ, 4, number of write requesters (2..8)
DATA_W, 124, array word width
DEPTH, 256, array entries
ADDR_W, 8, log2(DEPTH)
INIT_EN, 1, 1 = zero-fill sweep after reset; 0 = go straight to RUN

Ports:
clk  in  1  array clock
rst  in  1  asynchronous reset, active high
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  one-hot grant; a write transfers when valid & ready
req_addr  in  NUM_REQ*ADDR_W  packed write addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data
cfg_wr_block  in  1  quiesce: stop granting new writes
rd_en  in  1  array read enable (observed for bypass only)
rd_addr  in  ADDR_W  array read address
arr_wen  out  1  array write enable
arr_waddr  out  ADDR_W  array write address
arr_wdata  out  DATA_W  array write data
arr_wclk_en  out  1  enable to the write clock-gate cell
rd_byp_hit  out  1  read collides with the current write
rd_byp_data  out  DATA_W  data the reader uses on a hit
grant_id  out  $clog2(NUM_REQ)  index of the last granted requester
init_done  out  1  sweep complete
idle  out  1  no write in flight and no request pending

Behaviour:
- Reset (async, rst high): FSM=INIT (RUN if INIT_EN=0), sweep counter=0, RR pointer=0. All outputs 0. A write in flight is dropped.
- FSM states: INIT, RUN, BLOCK.
- INIT: req_ready=0. Each cycle writes address=counter with data=0. Counter increments and wraps at DEPTH-1. After writing DEPTH-1 the FSM goes to RUN and init_done is set and stays 1 until reset. A sweep takes exactly DEPTH cycles of arr_wen.
- RUN -> BLOCK when cfg_wr_block=1. BLOCK -> RUN when cfg_wr_block=0. Both transitions are registered. In BLOCK, req_ready=0.
- Grant in RUN (combinational, same cycle):
  - Search starts at requester ptr, increasing and wrapping.
  - The first requester with valid set gets req_ready.
  - On a transfer, ptr <= winner+1 (mod NUM_REQ) and grant_id <= winner. With no transfer, ptr holds.
  - req_ready does not depend on cfg_wr_block in the same cycle; the block takes effect the next cycle.
- Write stage: a transfer in cycle T registers addr/data. In T+1: arr_wen=1, arr_waddr/arr_wdata=registered values, arr_wclk_en=1. Latency is 1 cycle. Back-to-back transfers give one write per cycle with no bubbles. The array never back-pressures.
- arr_wclk_en==arr_wen in every cycle, including INIT.
- Bypass (combinational):
  - rd_byp_hit = rd_en & arr_wen & (rd_addr==arr_waddr).
  - rd_byp_data = arr_wdata on a hit, else 0.
  - Applies in INIT too, with data 0.
- idle = ~arr_wen & ~|req_valid & (state!=INIT).
- req_valid set for a requester while in INIT or BLOCK: the request stays pending with no transfer. Requesters must hold valid, addr and data until the transfer.
- Only one transfer per cycle. The arbiter must not starve a requester: with all NUM_REQ requesters continuously valid, each is granted once every NUM_REQ cycles.

Decomposition:
- Package arf124b256e1r1w0cbbehcaa4acw_wr_sched_pkg holds:
  - state enum (INIT/RUN/BLOCK)
  - ADDR_W and DATA_W defaults
  - RR index type
- One sub-module, arf124b256e1r1w0cbbehcaa4acw_rr_arb: parameterised round-robin arbiter with a pointer input and one-hot grant/index outputs. The FSM, sweep counter, write stage and bypass stay in the top.

Test Plan:
- Sweep: reset, INIT_EN=1 -> arr_wen for 256 consecutive cycles, addr 0..255, data 0. init_done rises the cycle after addr 255. req_ready=0 throughout.
- Round-robin: all 4 valid continuously after init -> grants 0,1,2,3,0,1... one per cycle. arr_waddr of each write matches the previous cycle's granted requester's addr.
- Single requester: only req 2 valid, addr 0x5A, data all-ones, ptr=0 -> req_ready=4'b0100. Next cycle arr_wen=1, waddr=0x5A. grant_id=2, ptr=3.
- Block: assert cfg_wr_block while reqs 0 and 1 are valid -> the in-flight write completes, no further ready, idle=0. Deassert -> grants resume from the saved ptr.
- Bypass: write addr 0x10, data 0xABC; read addr 0x10 in the arr_wen cycle -> rd_byp_hit=1, rd_byp_data=0xABC. Read addr 0x11 -> hit=0.
- Reset mid-sweep at addr 100 -> all outputs 0 immediately. After release, the sweep restarts at addr 0.
